// File: rtl/hazard_pipe_if.sv
// hazard_pipe_if: decode-side inputs and hazard/forwarding outputs of the three-stage hazard pipe.
// master: decode stage driving dec_* and flush, observing indices, write enables, stall, stall_cnt.
// slave : hazard_pipe consuming dec_*/flush and producing the stage outputs.
interface hazard_pipe_if;
  logic       dec_valid;
  logic [3:0] dec_rs1;
  logic [3:0] dec_rs2;
  logic       dec_use1;
  logic       dec_use2;
  logic [3:0] dec_rd;
  logic       dec_we;
  logic       dec_load;
  logic       flush;
  logic [3:0] RegReadIndex11;
  logic [3:0] RegReadIndex21;
  logic [3:0] RegWriteIndex2;
  logic       RegWrite2;
  logic [3:0] RegWriteIndex3;
  logic       RegWrite3;
  logic       stall;
  logic [7:0] stall_cnt;
  modport master (
    output dec_valid, dec_rs1, dec_rs2, dec_use1, dec_use2, dec_rd, dec_we, dec_load, flush,
    input  RegReadIndex11, RegReadIndex21, RegWriteIndex2, RegWrite2, RegWriteIndex3, RegWrite3,
           stall, stall_cnt
  );
  modport slave (
    input  dec_valid, dec_rs1, dec_rs2, dec_use1, dec_use2, dec_rd, dec_we, dec_load, flush,
    output RegReadIndex11, RegReadIndex21, RegWriteIndex2, RegWrite2, RegWriteIndex3, RegWrite3,
           stall, stall_cnt
  );
endinterface

// File: rtl/hazard_pipe.sv
// hazard_pipe: three-stage pipe tracking register use, detecting load-use hazards, and counting stalls.
// clk, rst_n (async active-low); bus: hazard_pipe_if.slave carrying dec_*, flush in and
// RegReadIndex11/21, RegWriteIndex2/3, RegWrite2/3, stall, stall_cnt out.
module hazard_pipe (
  input logic      clk,
  input logic      rst_n,
  hazard_pipe_if.slave bus
);
  logic       v1, use1, use2, we1, ld1;
  logic [3:0] rs1, rs2, rd1;
  logic       v2, we2, ld2;
  logic [3:0] rd2;
  logic       v3, we3;
  logic [3:0] rd3;
  logic [7:0] cnt;
  logic       h, stall, dv;
  assign h     = v1 & v2 & we2 & ld2 & ((use1 & (rs1 == rd2)) | (use2 & (rs2 == rd2)));
  assign stall = h & ~bus.flush;
  assign dv    = bus.dec_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {v1, use1, use2, we1, ld1, rs1, rs2, rd1} <= '0;
      {v2, we2, ld2, rd2} <= '0;
      {v3, we3, rd3} <= '0;
      cnt <= '0;
    end else begin
      {v3, we3, rd3} <= {v2, we2, rd2};
      {v2, we2, ld2, rd2} <= (bus.flush | stall) ? '0 : {v1, we1, ld1, rd1};
      if (bus.flush) begin
        {v1, use1, use2, we1, ld1, rs1, rs2, rd1} <= '0;
      end else if (!stall) begin
        v1   <= dv;
        use1 <= dv & bus.dec_use1;
        use2 <= dv & bus.dec_use2;
        we1  <= dv & bus.dec_we;
        ld1  <= dv & bus.dec_load;
        rs1  <= dv ? bus.dec_rs1 : 4'd0;
        rs2  <= dv ? bus.dec_rs2 : 4'd0;
        rd1  <= dv ? bus.dec_rd : 4'd0;
      end
      cnt <= cnt + {7'd0, stall & (cnt != 8'hff)};
    end
  end
  assign bus.RegReadIndex11 = rs1;
  assign bus.RegReadIndex21 = rs2;
  assign bus.RegWriteIndex2 = rd2;
  assign bus.RegWrite2      = v2 & we2;
  assign bus.RegWriteIndex3 = rd3;
  assign bus.RegWrite3      = v3 & we3;
  assign bus.stall          = stall;
  assign bus.stall_cnt      = cnt;
endmodule

// File: doc/hazard_pipe.md
HAZARD_PIPE -- requirements
Module: hazard_pipe

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 dec_valid  input  1  decoded instruction is present at stage 1 input.
REQ-005 dec_rs1, dec_rs2  input  4 each  source register indices.
REQ-006 dec_use1, dec_use2  input  1 each  instruction actually reads rs1 / rs2.
REQ-007 dec_rd  input  4  destination register index.
REQ-008 dec_we  input  1  instruction writes dec_rd.
REQ-009 dec_load  input  1  instruction is a memory load; data becomes available in stage 3.
REQ-010 flush  input  1  branch taken, resolved in stage 2; kill younger instructions.
REQ-011 RegReadIndex11, RegReadIndex21  output  4 each  stage-1 source indices for the forwarding unit.
REQ-012 RegWriteIndex2, RegWrite2  output  4 / 1  stage-2 destination and write enable.
REQ-013 RegWriteIndex3, RegWrite3  output  4 / 1  stage-3 destination and write enable.
REQ-014 stall  output  1  combinational; upstream SHALL hold all dec_* stable while high.
REQ-015 stall_cnt  output  8  saturating count of stall cycles since reset.

Function
REQ-016 Stage registers: S1 = {v1, rs1, rs2, use1, use2, rd, we, load}; S2 = {v2, rd, we, load}; S3 = {v3, rd, we}.
REQ-017 RegReadIndex11/21 SHALL equal the registered S1 rs1/rs2; RegWriteN SHALL equal vN & weN; RegWriteIndexN SHALL equal rdN.
REQ-018 Load-use hazard h = v1 & v2 & we2 & load2 & ((use1 & rs1==rd2) | (use2 & rs2==rd2)).
REQ-019 stall SHALL equal h & ~flush.
REQ-020 Normal advance (no flush, no stall): S3<=S2, S2<=S1, S1<=dec_* with v1<=dec_valid; latency decode to stage 3 = 2 cycles.
REQ-021 Stall (h & ~flush): S1 holds; S2 becomes a bubble (v2=0, we2=0, load2=0); S3<=S2; stall lasts exactly 1 cycle per load-use pair.
REQ-022 Flush: S3<=S2 (the branch proceeds); S2 and S1 become bubbles (v=0, we=0, load=0); dec_* are not captured that cycle.
REQ-023 Flush and stall in the same cycle: flush wins; stall is low; stall_cnt does not increment.
REQ-024 Bubble index fields (rs, rd) SHALL be forced to 0 so outputs are deterministic.
REQ-025 dec_valid=0: S1 captures a bubble; dec_we/dec_load are ignored.
REQ-026 Register index 0 SHALL be treated as an ordinary register (no special case).
REQ-027 stall_cnt increments by 1 on each clock edge where stall=1; it saturates at 255 and never wraps.

Reset
REQ-028 While rst_n=0, all v/we/load bits and all index fields SHALL be 0, and stall_cnt SHALL be 0.
REQ-029 Consequently, during and immediately after reset, all RegWrite*=0, all indices=0, and stall=0.
REQ-030 Reset asserted mid-stall SHALL discard all in-flight instructions; the first edge after release captures dec_* normally.

Verification
REQ-031 Scenario: ADD r3 (we, rd=3) then SUB reading rs1=3 on the next cycle -> no stall; a cycle later RegWrite2=1, RegWriteIndex2=3, RegReadIndex11=3.
REQ-032 Scenario: LOAD r5, then an instruction with rs2=5 and use2=1 -> stall=1 for exactly one cycle; next cycle RegWrite2=0 (bubble) and RegWrite3=1 with RegWriteIndex3=5; RegReadIndex21 stays 5 throughout; stall_cnt=1.
REQ-033 Scenario: LOAD r5, then an instruction with rs1=5 but use1=0 -> stall stays 0.
REQ-034 Scenario: LOAD r5 in S2, a reader of r5 in S1, and flush=1 in the same cycle -> stall=0; next cycle RegWrite2=0, v1=0, RegWrite3=1 with RegWriteIndex3=5; stall_cnt unchanged.
REQ-035 Scenario: 300 back-to-back load-use pairs -> stall_cnt reaches 255 and holds there.
REQ-036 Scenario: rst_n pulsed low asynchronously between edges while stall=1 -> outputs go to 0 immediately without waiting for a clock edge; stall_cnt=0.
